// File: rtl/counter_evt_pkg.sv
// Shared constants for counter_event_capture.
// Defining EVT_TIMESTAMP_EN widens each record with a 16-bit timestamp.
package counter_evt_pkg;

  // Bit positions inside the 4-bit flag field of a record.
  localparam int UP_WRAP_B = 3;
  localparam int DN_STEP_B = 2;
  localparam int DN_WRAP_B = 1;
  localparam int UP_ERR_B  = 0;

  localparam int FLAG_W = 4;
  localparam int TS_W   = 16;

  function automatic int rec_w(input int cnt_w);
`ifdef EVT_TIMESTAMP_EN
    return TS_W + FLAG_W + 2 * cnt_w;
`else
    return FLAG_W + 2 * cnt_w;
`endif
  endfunction

endpackage

// File: rtl/counter_event_capture_evt_fifo.sv
// Synchronous FIFO with a registered head word; a push into a full FIFO
// is ignored unless a pop frees a slot in the same cycle.
module evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   count_reg;
  logic [W-1:0]  head_reg;
  logic          do_push;
  logic          do_pop;

  assign full        = (count_reg == CNT_FULL);
  assign empty       = (count_reg == '0);
  assign do_pop      = pop && !empty;
  assign do_push     = push && (!full || do_pop);
  assign rd_ptr_next = rd_ptr_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // head_reg always mirrors mem[rd_ptr_reg]; a word pushed into an empty
  // (or emptying) FIFO is captured straight from wdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_next;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (do_pop && (count_reg > CNT_ONE)) begin
        head_reg <= mem[rd_ptr_next];
      end else if (do_push && (empty || (do_pop && (count_reg == CNT_ONE)))) begin
        head_reg <= wdata;
      end
    end
  end

  assign rdata = head_reg;
  assign count = count_reg;

endmodule

// File: rtl/counter_event_capture.sv
// Watches an up/down counter pair and queues one event record per cycle
// with any flag set. Optional timestamp field: EVT_TIMESTAMP_EN.
module counter_event_capture
  import counter_evt_pkg::*;
#(
  parameter int  CNT_W = 4,
  parameter int  DEPTH = 4,
  localparam int REC_W = rec_w(CNT_W)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CNT_W-1:0]       up_cnt,
  input  logic [CNT_W-1:0]       dn_cnt,
  input  logic                   evt_ready,
  input  logic                   clr_ovf,
  output logic                   evt_valid,
  output logic [REC_W-1:0]       evt_data,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic                   overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  prev_up_reg;
  logic [CNT_W-1:0]  prev_dn_reg;
  logic [CNT_W-1:0]  up_inc;
  logic [CNT_W-1:0]  dn_dec;
  logic [FLAG_W-1:0] flags;
  logic [REC_W-1:0]  rec;
  logic              push;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              overflow_reg;

  assign up_inc = prev_up_reg + 1'b1;
  assign dn_dec = prev_dn_reg - 1'b1;

  always_comb begin
    flags            = '0;
    flags[UP_WRAP_B] = (prev_up_reg == CNT_MAX) && (up_cnt == '0);
    flags[DN_STEP_B] = (dn_cnt == dn_dec);
    flags[DN_WRAP_B] = (prev_dn_reg == '0) && (dn_cnt == CNT_MAX);
    flags[UP_ERR_B]  = (up_cnt != up_inc);
  end

  // Reset values match the counters' own reset so a common reset is quiet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_up_reg <= '0;
      prev_dn_reg <= CNT_MAX;
    end else begin
      prev_up_reg <= up_cnt;
      prev_dn_reg <= dn_cnt;
    end
  end

`ifdef EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_reg <= '0;
    end else begin
      ts_reg <= ts_reg + 1'b1;
    end
  end

  assign rec = {ts_reg, flags, up_cnt, dn_cnt};
`else
  assign rec = {flags, up_cnt, dn_cnt};
`endif

  assign push = |flags;
  assign pop  = evt_valid && evt_ready;
  assign drop = push && fifo_full && !pop;

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (clr_ovf) begin
      overflow_reg <= 1'b0;
    end
  end

  evt_fifo #(
    .DEPTH(DEPTH),
    .W    (REC_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(rec),
    .rdata(evt_data),
    .count(evt_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_counter_event_capture.sv
// Directed bench for counter_event_capture with a queue-based scoreboard;
// builds with or without EVT_TIMESTAMP_EN.
module tb_counter_event_capture;

  localparam int CNT_W = 4;
  localparam int DEPTH = 4;
`ifdef EVT_TIMESTAMP_EN
  localparam int REC_W = 16 + 4 + 2 * CNT_W;
`else
  localparam int REC_W = 4 + 2 * CNT_W;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [CNT_W-1:0] up_cnt;
  logic [CNT_W-1:0] dn_cnt;
  logic             evt_ready;
  logic             clr_ovf;
  logic             evt_valid;
  logic [REC_W-1:0] evt_data;
  logic [2:0]       evt_count;
  logic             overflow;

  always #5 clk = ~clk;

  counter_event_capture #(
    .CNT_W(CNT_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .up_cnt   (up_cnt),
    .dn_cnt   (dn_cnt),
    .evt_ready(evt_ready),
    .clr_ovf  (clr_ovf),
    .evt_valid(evt_valid),
    .evt_data (evt_data),
    .evt_count(evt_count),
    .overflow (overflow)
  );

  logic [REC_W-1:0] sb[$];
  int               errors = 0;
  int               checks = 0;
  logic [3:0]       m_prev_up;
  logic [3:0]       m_prev_dn;
  logic             m_ovf;
  logic [15:0]      m_ts;
  logic [3:0]       cu;
  logic [3:0]       cd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] mkrec(input logic [3:0] f, input logic [3:0] u, input logic [3:0] d);
`ifdef EVT_TIMESTAMP_EN
    return {m_ts, f, u, d};
`else
    return {f, u, d};
`endif
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".valid"}, 32'(evt_valid), 32'(sb.size() != 0));
    chk({tag, ".count"}, 32'(evt_count), 32'(sb.size()));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    if (sb.size() != 0) chk({tag, ".head"}, 32'(evt_data), 32'(sb[0]));
  endtask

  // One clock: drive inputs, update the model, sample 1 ns after the edge.
  task automatic step(input string tag, input logic [3:0] u, input logic [3:0] d,
                      input logic rdy, input logic clr);
    logic [3:0]       f;
    logic             drop;
    logic [REC_W-1:0] tmp;
    up_cnt    = u;
    dn_cnt    = d;
    evt_ready = rdy;
    clr_ovf   = clr;
    f[3] = (m_prev_up == 4'hF) && (u == 4'h0);
    f[2] = (d == 4'(m_prev_dn - 4'd1));
    f[1] = (m_prev_dn == 4'h0) && (d == 4'hF);
    f[0] = (u != 4'(m_prev_up + 4'd1));
    drop = 1'b0;
    if (rdy && sb.size() != 0) tmp = sb.pop_front();
    if (f != 4'h0) begin
      if (sb.size() < DEPTH) sb.push_back(mkrec(f, u, d));
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_prev_up = u;
    m_prev_dn = d;
    m_ts      = m_ts + 16'd1;
    cu        = u;
    cd        = d;
    @(posedge clk);
    #1;
    $display("%s: up=%h dn=%h rdy=%b clr=%b flags=%b valid=%b count=%0d ovf=%b data=%h",
             tag, u, d, rdy, clr, f, evt_valid, evt_count, overflow, evt_data);
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    sb.delete();
    m_ovf     = 1'b0;
    m_prev_up = 4'h0;
    m_prev_dn = 4'hF;
    m_ts      = 16'd0;
    chk({tag, ".valid"}, 32'(evt_valid), 32'd0);
    chk({tag, ".count"}, 32'(evt_count), 32'd0);
    chk({tag, ".ovf"}, 32'(overflow), 32'd0);
    chk({tag, ".data"}, 32'(evt_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    $display("%s: reset released", tag);
  endtask

  initial begin
    reset     = 1'b0;
    up_cnt    = 4'h0;
    dn_cnt    = 4'hF;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    cu        = 4'h0;
    cd        = 4'hF;
    #2;
    do_reset("rst0");

    // Up counter full lap: only the 15->0 wrap produces a record.
    for (int i = 1; i <= 16; i++) step("t1.lap", 4'(i), 4'hF, 1'b0, 1'b0);
    chk("t1.count1", 32'(evt_count), 32'd1);
    chk("t1.rec", 32'(evt_data[11:0]), 32'h80F);
    step("t1.drain", 4'(cu + 4'd1), cd, 1'b1, 1'b0);

    // Down step alongside a normal up increment.
    while (cu != 4'hC) step("t2.run", 4'(cu + 4'd1), cd, 1'b0, 1'b0);
    step("t2.dnstep", 4'hD, 4'hE, 1'b0, 1'b0);
    chk("t2.rec", 32'(evt_data[11:0]), 32'h4DE);
    step("t2.drain", 4'(cu + 4'd1), cd, 1'b1, 1'b0);

    // Down counter runs to 0 then wraps to 15.
    while (cd != 4'h0) step("t3.dn", 4'(cu + 4'd1), 4'(cd - 4'd1), 1'b1, 1'b0);
    step("t3.quiet", 4'(cu + 4'd1), cd, 1'b1, 1'b0);
    step("t3.wrap", 4'(cu + 4'd1), 4'hF, 1'b0, 1'b0);
    chk("t3.rec", 32'(evt_data[11:0]), 32'({4'b0110, cu, 4'hF}));
    step("t3.drain", 4'(cu + 4'd1), cd, 1'b1, 1'b0);

    // Five events with the consumer stalled: fourth fills, fifth drops.
    for (int k = 0; k < 5; k++) step("t4.fill", 4'(cu + 4'd1), 4'(cd - 4'd1), 1'b0, 1'b0);
    chk("t4.full", 32'(evt_count), 32'd4);
    chk("t4.ovf1", 32'(overflow), 32'd1);
    step("t4.clr", 4'(cu + 4'd1), cd, 1'b0, 1'b1);
    chk("t4.ovf0", 32'(overflow), 32'd0);

    // Push and pop together while full.
    step("t5.pushpop", 4'(cu + 4'd1), 4'(cd - 4'd1), 1'b1, 1'b0);
    chk("t5.count", 32'(evt_count), 32'd4);
    for (int k = 0; k < 4; k++) step("t5.drain", 4'(cu + 4'd1), cd, 1'b1, 1'b0);

    // Up counter jumps 5->9, then reset arrives mid-stream.
    while (cu != 4'h5) step("t6.run", 4'(cu + 4'd1), cd, 1'b1, 1'b0);
    step("t6.jump", 4'h9, cd, 1'b0, 1'b0);
    chk("t6.rec", 32'(evt_data[11:0]), 32'({4'b0001, 4'h9, cd}));
    do_reset("t6.rst");

    // After reset, the counters restart from their reset values.
    step("t7.run", 4'h1, 4'hF, 1'b0, 1'b0);
    step("t7.run", 4'h2, 4'hF, 1'b0, 1'b0);
    step("t7.run", 4'h3, 4'hF, 1'b0, 1'b0);
    step("t7.evt", 4'h4, 4'hE, 1'b0, 1'b0);
    chk("t7.rec", 32'(evt_data[11:0]), 32'h44E);
`ifdef EVT_TIMESTAMP_EN
    chk("t7.ts", 32'(evt_data[REC_W-1 -: 16]), 32'd3);
`endif
    step("t7.drain", 4'h5, 4'hE, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_event_capture.md
# counter_event_capture

Downstream consumer of the up/down counter pair. Samples both 4-bit counter values every cycle, detects up-counter wrap, down-counter step, down-counter wrap and up-counter sequence errors, and queues one event record per active cycle in a small FIFO. A valid/ready port hands records to the next stage, such as a logger or a bus bridge.

## Interface
- CNT_W, 4: width of each counter input.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- clk  in  1  rising-edge clock, same domain as the counters.
- reset  in  1  asynchronous, active-high reset.
- up_cnt  in  CNT_W  up-counter value.
- dn_cnt  in  CNT_W  down-counter value.
- evt_ready  in  1  consumer accepts the head record.
- clr_ovf  in  1  synchronous clear of the overflow flag.
- evt_valid  out  1  head record available.
- evt_data  out  REC_W  head record {up_wrap, dn_step, dn_wrap, up_err, up_cnt, dn_cnt}. REC_W = 4+2·CNT_W, or 20+2·CNT_W with the timestamp feature.
- evt_count  out  clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky flag: a record was dropped.

## Operation
- Prev registers: prev_up resets to 0 and prev_dn resets to all-ones, matching the counter reset values. This prevents false events after a common reset.
- Flags are computed combinationally from the inputs and prev registers (all arithmetic mod 2^CNT_W):
  - up_wrap = prev_up==max && up_cnt==0.
  - dn_step = dn_cnt==prev_dn−1.
  - dn_wrap = prev_dn==0 && dn_cnt==max. This implies dn_step.
  - up_err = up_cnt≠prev_up+1.
- Each cycle, prev registers load the current inputs unconditionally.
- A record is pushed when any flag is set. Several flags may be set in the same record; there is no priority. The record carries the current (post-event) counter values.
- Pop occurs when evt_valid && evt_ready.
- Push into a full FIFO without a simultaneous pop:
  - The record is dropped and overflow is set.
  - FIFO contents are unchanged.
- Push and pop in the same cycle when full: both succeed and occupancy stays DEPTH. No overflow.
- Push and pop in the same cycle when empty: the record is written and becomes visible next cycle. No bypass.
- clr_ovf clears overflow. If a drop occurs in the same cycle, set wins.
- evt_data is held stable while evt_valid && !evt_ready.
- Pointers wrap modulo DEPTH. evt_count runs 0..DEPTH.

## Timing
- Reset values:
  - evt_valid=0, evt_count=0, overflow=0, evt_data=0.
  - Pointers=0, prev_up=0, prev_dn=all-ones, timestamp=0.
- Latency: inputs sampled at edge E that produce an event give evt_valid=1 after edge E, provided the FIFO was empty.
- Throughput: one push and one pop per cycle.
- Reset asserted mid-operation: the FIFO empties immediately (asynchronously) and in-flight records are lost. After reset releases, the first sampled cycle is compared against the reset prev values.
- evt_ready may be asserted without evt_valid; it then has no effect.

## Configuration
- EVT_TIMESTAMP_EN defined:
  - A 16-bit free-running cycle counter, reset 0, wraps at 0xFFFF.
  - Its value at push is prepended as evt_data[REC_W−1 -: 16].
- EVT_TIMESTAMP_EN not defined:
  - No timestamp counter is built.
  - REC_W = 4+2·CNT_W.
  - All other behaviour is identical.

## Structure
- Package counter_evt_pkg holds:
  - Flag bit index constants (UP_WRAP_B, DN_STEP_B, DN_WRAP_B, UP_ERR_B).
  - TS_W=16.
  - A function returning REC_W from CNT_W.
- Sub-module evt_fifo(DEPTH, W): storage, pointers, occupancy, full/empty. Push-when-full is ignored inside it; the drop and overflow logic sits in the top level.

## Test plan
- Reset, then up_cnt 0→1→…→15→0 while dn_cnt stays 15 → exactly one record {up_wrap=1, up=0, dn=15}; no others.
- Drive up 12→13 while dn 15→14 → record with dn_step=1, up=13, dn=14; evt_valid the cycle after the sampling edge.
- Drive dn 0→15 with up incrementing → record with dn_step=1 and dn_wrap=1.
- Hold evt_ready=0 and generate 5 events with DEPTH=4 → evt_count=4, overflow=1, first 4 records retained in order. Assert clr_ovf → overflow=0.
- With the FIFO full, assert evt_ready and an event in the same cycle → evt_count stays 4, overflow stays 0, head advances.
- Drive up 5→9, then assert reset mid-stream → up_err record produced before reset; after reset, evt_valid=0 and evt_count=0. With EVT_TIMESTAMP_EN, the timestamp field equals the cycle index since reset.
